alu_exec_unit: RTL
==================

// Module: alu_exec_unit
// PURPOSE
//  Execute-stage ALU that consumes the 4-bit ALU control code produced by the ALU
//  control decoder and performs the operation on two XLEN operands.
//  Valid/ready on both sides; a 2-entry skid buffer keeps in_ready registered and
//  lets the stage absorb one cycle of downstream stall without losing data.
//  Also flags illegal codes and keeps a saturating count of them for debug.
// PARAMETERS
//  XLEN       32  operand/result width
//  ERR_CNT_W  8   width of saturating illegal-op counter
// PORTS
//  clk        in   1          system clock, rising edge
//  rst        in   1          asynchronous, active-high reset
//  in_valid   in   1          operation presented
//  in_ready   out  1          unit can accept; transfer when in_valid&&in_ready
//  alu_ctrl   in   4          ALU control lines from decoder
//  dec_err    in   1          decoder error flag accompanying alu_ctrl
//  op_a       in   XLEN       operand A (rs1)
//  op_b       in   XLEN       operand B (rs2 or immediate)
//  out_valid  out  1          result available
//  out_ready  in   1          consumer accepts; transfer when out_valid&&out_ready
//  result     out  XLEN       operation result
//  zero       out  1          result == 0 (branch compare)
//  overflow   out  1          signed overflow, ADD/SUB only, else 0
//  illegal    out  1          op was illegal (bad code or dec_err)
//  err_count  out  ERR_CNT_W  number of illegal ops accepted, saturating
// BEHAVIOUR
//  Reset (async, rst=1): out_valid=0, result=0, zero=0, overflow=0, illegal=0,
//   err_count=0, both buffer entries empty, in_ready=1 after reset releases.
//   Reset mid-operation discards any buffered ops; no partial output.
//  Codes: 0000 AND | 0001 OR | 0010 ADD | 0110 SUB | 0111 SLT (signed, result
//   0 or 1) | 1100 NOR. Any other code, or dec_err=1: result=0, zero=1,
//   overflow=0, illegal=1 (dec_err dominates over a legal code).
//  Arithmetic modulo 2^XLEN. ADD ovf: a,b same sign, sum sign differs.
//   SUB ovf: a,b signs differ, diff sign differs from a.
//  Result computed combinationally at accept, registered with its flags.
//  Latency: op accepted in cycle N -> out_valid=1 with its result in N+1.
//  Storage: main output reg (drives outputs) + one skid entry.
//   - Accept when main empty or draining this cycle -> write main.
//   - Accept while main full and not draining -> write skid.
//   - Main draining and skid full -> skid moves to main, skid empties.
//  in_ready (registered) = skid entry empty next cycle. Both full -> in_ready=0.
//  Outputs hold stable while out_valid=1 and out_ready=0.
//  Order strictly preserved; no drop, no duplication.
//  Simultaneous accept+drain with skid full impossible (in_ready=0 then).
//  Simultaneous accept+drain with main full, skid empty: new op goes to main.
//  err_count increments by 1 on each accepted illegal op, saturates at all-ones.
//  out_valid and illegal do not depend combinationally on in_* or out_ready.
// TESTING
//  1 ADD a=0x7FFFFFFF b=1, out_ready=1 -> next cycle result=0x80000000,
//    overflow=1, zero=0, illegal=0.
//  2 SUB a=5 b=5 -> result=0, zero=1, overflow=0; SLT a=0xFFFFFFFF b=1 -> result=1.
//  3 Back-to-back AND,OR,NOR with out_ready=0 for 3 cycles: in_ready drops after
//    2 accepts; release -> results appear in order, third op then accepted.
//  4 alu_ctrl=0011, then ADD with dec_err=1 -> illegal=1, result=0, err_count=2;
//    300 illegal ops -> err_count=0xFF holds.
//  5 rst pulsed with both entries full -> out_valid=0, err_count=0, in_ready=1
//    after release; no stale result emerges.
//  6 Random valid/ready throttling, 10k ops vs reference model: zero mismatches.

Source files
------------

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU behind a valid/ready skid buffer. Results are registered
// one cycle after accept. A saturating counter tracks accepted illegal ops.
module alu_exec_unit #(
    parameter int XLEN      = 32,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           alu_ctrl,
    input  logic                 dec_err,
    input  logic [XLEN-1:0]      op_a,
    input  logic [XLEN-1:0]      op_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      result,
    output logic                 zero,
    output logic                 overflow,
    output logic                 illegal,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic            zero;
        logic            overflow;
        logic            illegal;
    } entry_t;

    entry_t          new_entry;
    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] diff;

    assign sum  = op_a + op_b;
    assign diff = op_a - op_b;

    // Operation evaluated at accept time; dec_err overrides any legal code.
    always_comb begin
        new_entry = '0;
        if (dec_err) begin
            new_entry.illegal = 1'b1;
        end else begin
            case (alu_ctrl)
                OP_AND: new_entry.result = op_a & op_b;
                OP_OR:  new_entry.result = op_a | op_b;
                OP_ADD: begin
                    new_entry.result   = sum;
                    new_entry.overflow = (op_a[XLEN-1] == op_b[XLEN-1]) &&
                                         (sum[XLEN-1] != op_a[XLEN-1]);
                end
                OP_SUB: begin
                    new_entry.result   = diff;
                    new_entry.overflow = (op_a[XLEN-1] != op_b[XLEN-1]) &&
                                         (diff[XLEN-1] != op_a[XLEN-1]);
                end
                OP_SLT: new_entry.result = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
                OP_NOR: new_entry.result = ~(op_a | op_b);
                default: new_entry.illegal = 1'b1;
            endcase
        end
        new_entry.zero = (new_entry.result == '0);
    end

    logic                 main_valid_reg, main_valid_next;
    entry_t               main_reg, main_next;
    logic                 skid_valid_reg, skid_valid_next;
    entry_t               skid_reg, skid_next;
    logic                 in_ready_reg;
    logic [ERR_CNT_W-1:0] err_count_reg;
    logic                 accept;
    logic                 drain;

    assign accept = in_valid && in_ready_reg;
    assign drain  = main_valid_reg && out_ready;

    // Skid is only filled while main is stalled, and it always refills main
    // first when main drains, so main is never empty with the skid occupied.
    always_comb begin
        main_valid_next = main_valid_reg;
        main_next       = main_reg;
        skid_valid_next = skid_valid_reg;
        skid_next       = skid_reg;
        if (drain) begin
            if (skid_valid_reg) begin
                main_next       = skid_reg;
                skid_valid_next = 1'b0;
            end else if (accept) begin
                main_next = new_entry;
            end else begin
                main_valid_next = 1'b0;
            end
        end else if (!main_valid_reg) begin
            if (accept) begin
                main_valid_next = 1'b1;
                main_next       = new_entry;
            end
        end else if (accept) begin
            skid_valid_next = 1'b1;
            skid_next       = new_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid_reg <= 1'b0;
            main_reg       <= '0;
            skid_valid_reg <= 1'b0;
            skid_reg       <= '0;
            in_ready_reg   <= 1'b1;
            err_count_reg  <= '0;
        end else begin
            main_valid_reg <= main_valid_next;
            main_reg       <= main_next;
            skid_valid_reg <= skid_valid_next;
            skid_reg       <= skid_next;
            in_ready_reg   <= !skid_valid_next;
            if (accept && new_entry.illegal && (err_count_reg != '1)) begin
                err_count_reg <= err_count_reg + ERR_CNT_W'(1);
            end
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = main_valid_reg;
    assign result    = main_reg.result;
    assign zero      = main_reg.zero;
    assign overflow  = main_reg.overflow;
    assign illegal   = main_reg.illegal;
    assign err_count = err_count_reg;

endmodule
